alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle execution unit that consumes the 3-bit `alucontrol` code produced by the ALU decoder and performs the selected operation on two n-bit operands. Single-cycle ops complete in one clock; `mult` runs an iterative signed shift-add multiplier into HI/LO registers. It sits in the execute stage of the multicycle datapath, handshaking with the control FSM via `start`/`busy`/`done`.

## Interface
- `n`, default 32: operand, result, HI and LO width.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled on a rising edge when `busy`=0
- `a`  in  n  operand A (rs)
- `b`  in  n  operand B (rt/immediate)
- `alucontrol`  in  3  operation code (below)
- `busy`  out  1  multiply in progress; `start` ignored while high
- `done`  out  1  one-cycle pulse: `result`/`zero` (and HI/LO for mult) valid
- `result`  out  n  registered result
- `zero`  out  1  registered branch flag
- `hi`  out  n  upper product half
- `lo`  out  n  lower product half

## Operation
- Codes: 000 and, 001 or, 010 add, 110 sub, 111 slt (signed), 100 nor, 011 mult (signed), 101 bne-compare.
- add/sub wrap modulo 2^n; no overflow flag.
- slt: `result` = 1 if $signed(a) < $signed(b), else 0, zero-extended.
- Codes 000/001/010/110/111/100: `zero` = (`result` == 0).
- 101: `result` = a − b; `zero` = (a != b), so the branch unit tests `zero` uniformly for beq and bne.
- 011: product of $signed(a) × $signed(b) split into {hi, lo} (2n bits); `result` = lo; `zero` = (full 2n-bit product == 0).
- Multiplier: on accept, load |a| and |b| and latch sign = a[n-1]^b[n-1]. Run n shift-add iterations on a 2n-bit accumulator. On the final iteration, negate the accumulator if sign=1, then write HI/LO.
- HI/LO change only on mult completion and hold otherwise.
- FSM states:
  - IDLE: accept `start`. mult → MULT with count=0; any other code → compute, stay IDLE.
  - MULT: count increments every cycle; at count=n−1 → IDLE, writing result, zero, hi, lo.
- Inputs `a`, `b` and `alucontrol` are captured at accept. Later changes do not affect an operation in flight.

## Timing
- Reset (async, immediate): state IDLE; `busy`, `done`, `result`, `zero`, `hi`, `lo` all 0; multiplier counter and accumulator cleared.
- Non-mult: `start` sampled at edge E0. `result`/`zero` update at E0, and `done`=1 for the cycle following E0. Latency 1.
- Mult: accepted at E0, `busy`=1 from E0. Iterations run on edges E1..En. At En: HI/LO/result/zero are written, `busy`→0, and `done`=1 for the cycle following En. Latency n+1 (33 for n=32).
- `done` is high for exactly one cycle per accepted request and never without one.
- Back-to-back: `start` may be asserted during the `done` cycle (`busy`=0 then). It is accepted, so a new op can issue every cycle for non-mult codes.
- `start` while `busy`=1: ignored, no state change, no extra `done`.
- Reset during MULT: operation aborted, all outputs 0, no `done`. HI/LO are not written with partial results.
- Outputs `result`/`zero` hold their last value between operations.

## Test plan
- Reset then add: a=7, b=5, code 010 → `done` next cycle, `result`=12, `zero`=0. Then sub 5−5 (110) → `result`=0, `zero`=1.
- slt and nor: a=0xFFFFFFFF, b=1, code 111 → `result`=1. Code 100 with a=0x0F0F0F0F, b=0xF0F0F0F0 → `result`=0, `zero`=1.
- bne compare: a=3, b=4, code 101 → `zero`=1. a=b=9 → `zero`=0, `result`=0.
- Signed mult, n=32: a=−3, b=7 → `busy` for 32 cycles, `done` 33 cycles after accept, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Also a=0x80000000, b=0x80000000 → `hi`=0x40000000, `lo`=0.
- `start` pulsed with add during `busy` → ignored: exactly one `done`, HI/LO match the mult. An add issued in the `done` cycle completes one cycle later.
- Reset asserted mid-mult (cycle 10) → all outputs 0 immediately, no `done`. A following mult 6×7 gives `lo`=42, `hi`=0.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : multi-cycle execute-stage ALU for the multicycle datapath.
//
// Single-cycle operations (and/or/add/sub/slt/nor/bne-compare) finish on the
// accepting edge. Signed multiply runs an n-iteration shift-add on magnitudes
// and applies the sign on the last iteration, then writes HI/LO.
//
// Ports
//   clk        in  1  rising-edge clock
//   reset      in  1  asynchronous, active-high reset
//   start      in  1  request, accepted on a rising edge while busy = 0
//   a          in  n  operand A (rs)
//   b          in  n  operand B (rt / immediate)
//   alucontrol in  3  operation code
//   busy       out 1  multiply in progress, start ignored while high
//   done       out 1  one-cycle pulse, result/zero (and hi/lo for mult) valid
//   result     out n  registered result
//   zero       out 1  registered branch flag
//   hi         out n  upper half of last product
//   lo         out n  lower half of last product
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic [2:0]   alucontrol,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] result,
   output logic         zero,
   output logic [n-1:0] hi,
   output logic [n-1:0] lo
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [CW-1:0] LAST    = CW'(n - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_MULT = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_BNE  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   localparam logic [n-1:0]   ZERO_N  = {n{1'b0}};
   localparam logic [n-1:0]   ONE_N   = {{(n-1){1'b0}}, 1'b1};
   localparam logic [2*n-1:0] ZERO_2N = {(2*n){1'b0}};
   localparam logic [2*n-1:0] ONE_2N  = {{(2*n-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MULT = 1'b1
   } state_t;

   // Magnitude of a two's-complement value; the most negative value maps to
   // itself, which is the correct unsigned magnitude.
   function automatic logic [n-1:0] abs_val(input logic [n-1:0] v);
      logic [n-1:0] r;
      if (v[n-1]) begin
         r = ~v + ONE_N;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Two's-complement negation of the full-width accumulator.
   function automatic logic [2*n-1:0] neg_2n(input logic [2*n-1:0] v);
      return ~v + ONE_2N;
   endfunction

   // One shift-add iteration. The multiplier sits in the low half of the
   // accumulator; its LSB gates the add of the multiplicand into the high half,
   // and the carry is kept by shifting the (n+1)-bit sum back in at the top.
   function automatic logic [2*n-1:0] mult_step(input logic [2*n-1:0] acc,
                                                input logic [n-1:0]   mcand);
      logic [n:0] addend;
      logic [n:0] sum;
      addend = {1'b0, mcand} & {(n+1){acc[0]}};
      sum    = {1'b0, acc[2*n-1:n]} + addend;
      return {sum, acc[n-1:1]};
   endfunction

   // Single-cycle operations; returns {zero, result}.
   function automatic logic [n:0] alu_eval(input logic [2:0]   op,
                                           input logic [n-1:0] x,
                                           input logic [n-1:0] y);
      logic [n-1:0] r;
      logic         z;
      r = ZERO_N;
      z = 1'b1;
      case (op)
         OP_AND: r = x & y;
         OP_OR:  r = x | y;
         OP_ADD: r = x + y;
         OP_SUB: r = x - y;
         OP_SLT: r = ($signed(x) < $signed(y)) ? ONE_N : ZERO_N;
         OP_NOR: r = ~(x | y);
         OP_BNE: r = x - y;
         default: r = ZERO_N;
      endcase
      // bne-compare inverts the sense so the branch unit always tests zero.
      if (op == OP_BNE) begin
         z = (x != y);
      end else begin
         z = (r == ZERO_N);
      end
      return {z, r};
   endfunction

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [2*n-1:0]  acc_q, acc_d;
   logic [n-1:0]    mcand_q, mcand_d;
   logic            sign_q, sign_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [n-1:0]    result_q, result_d;
   logic            zero_q, zero_d;
   logic [n-1:0]    hi_q, hi_d;
   logic [n-1:0]    lo_q, lo_d;

   logic [2*n-1:0]  step_s;
   logic [2*n-1:0]  prod_s;
   logic [n:0]      alu_s;

   // Next-state and next-output computation for the IDLE/MULT controller.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      sign_d   = sign_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      step_s = mult_step(acc_q, mcand_q);
      // Sign is applied only to the finished magnitude product.
      if (sign_q) begin
         prod_s = neg_2n(step_s);
      end else begin
         prod_s = step_s;
      end
      alu_s = alu_eval(alucontrol, a, b);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (alucontrol == OP_MULT) begin
                  state_d = S_MULT;
                  count_d = {CW{1'b0}};
                  acc_d   = {ZERO_N, abs_val(b)};
                  mcand_d = abs_val(a);
                  sign_d  = a[n-1] ^ b[n-1];
                  busy_d  = 1'b1;
               end else begin
                  result_d = alu_s[n-1:0];
                  zero_d   = alu_s[n];
                  done_d   = 1'b1;
               end
            end else begin
               busy_d = 1'b0;
            end
         end
         S_MULT: begin
            // start is deliberately not looked at here.
            if (count_q == LAST) begin
               state_d  = S_IDLE;
               count_d  = {CW{1'b0}};
               acc_d    = prod_s;
               hi_d     = prod_s[2*n-1:n];
               lo_d     = prod_s[n-1:0];
               result_d = prod_s[n-1:0];
               zero_d   = (prod_s == ZERO_2N);
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end else begin
               acc_d   = step_s;
               count_d = count_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = {CW{1'b0}};
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any multiply in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         count_q  <= {CW{1'b0}};
         acc_q    <= ZERO_2N;
         mcand_q  <= ZERO_N;
         sign_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= ZERO_N;
         zero_q   <= 1'b0;
         hi_q     <= ZERO_N;
         lo_q     <= ZERO_N;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         sign_q   <= sign_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;
   assign hi     = hi_q;
   assign lo     = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : self-checking bench for alu_seq (n = 32).
// Expected results are pushed to a scoreboard queue when a request is driven
// and popped when the DUT raises done.
// -----------------------------------------------------------------------------
module tb_alu_seq;

   localparam int N = 32;

   localparam logic [2:0] C_AND  = 3'b000;
   localparam logic [2:0] C_OR   = 3'b001;
   localparam logic [2:0] C_ADD  = 3'b010;
   localparam logic [2:0] C_MULT = 3'b011;
   localparam logic [2:0] C_NOR  = 3'b100;
   localparam logic [2:0] C_BNE  = 3'b101;
   localparam logic [2:0] C_SUB  = 3'b110;
   localparam logic [2:0] C_SLT  = 3'b111;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic [2:0]   alucontrol;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         zero;
   logic [N-1:0] hi;
   logic [N-1:0] lo;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [N-1:0] res;
      logic         z;
      logic [N-1:0] hi;
      logic [N-1:0] lo;
      int           lat;
   } exp_t;

   exp_t         scb[$];
   logic [N-1:0] m_hi = 32'h0;
   logic [N-1:0] m_lo = 32'h0;

   always #5 clk = ~clk;

   alu_seq #(.n(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
      .alucontrol (alucontrol),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .zero       (zero),
      .hi         (hi),
      .lo         (lo)
   );

   // Called at a negedge: presents a request for one cycle and records the
   // expected outcome. Returns at the negedge after the accepting edge.
   task automatic drive_start(input logic [2:0] code, input logic [N-1:0] aa,
                              input logic [N-1:0] bb);
      exp_t        e;
      longint      sa;
      longint      sbv;
      longint      p;
      logic [63:0] pu;
      pu    = 64'h0;
      e.hi  = m_hi;
      e.lo  = m_lo;
      e.lat = 0;
      case (code)
         C_AND:  e.res = aa & bb;
         C_OR:   e.res = aa | bb;
         C_ADD:  e.res = aa + bb;
         C_SUB:  e.res = aa - bb;
         C_SLT:  e.res = ($signed(aa) < $signed(bb)) ? 32'd1 : 32'd0;
         C_NOR:  e.res = ~(aa | bb);
         C_BNE:  e.res = aa - bb;
         default: begin
            sa    = $signed(aa);
            sbv   = $signed(bb);
            p     = sa * sbv;
            pu    = p;
            e.hi  = pu[63:32];
            e.lo  = pu[31:0];
            e.res = pu[31:0];
            e.lat = N;
            m_hi  = e.hi;
            m_lo  = e.lo;
         end
      endcase
      if (code == C_BNE) e.z = (aa != bb);
      else if (code == C_MULT) e.z = (pu == 64'h0);
      else e.z = (e.res == 32'h0);
      scb.push_back(e);
      start      = 1'b1;
      alucontrol = code;
      a          = aa;
      b          = bb;
      @(negedge clk);
      start      = 1'b0;
      a          = $urandom;
      b          = $urandom;
      alucontrol = 3'($urandom_range(7, 0));
   endtask

   // Waits (bounded) for done, then pops the scoreboard and compares.
   // skip = negedges already consumed since the first post-accept negedge.
   task automatic check_done(input string name, input int skip);
      int   cnt;
      int   bsy;
      exp_t e;
      cnt = 0;
      bsy = 0;
      while (done !== 1'b1 && cnt < 100) begin
         if (busy === 1'b1) bsy++;
         @(negedge clk);
         cnt++;
      end
      total++;
      if (cnt >= 100) begin
         bad++;
         $display("FAIL %s timeout: done not seen within %0d cycles", name, cnt);
         if (scb.size() > 0) void'(scb.pop_front());
         return;
      end
      if (scb.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard: done seen with no request pending", name);
         return;
      end
      e = scb.pop_front();
      if (cnt !== e.lat - skip) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", name, cnt, e.lat - skip);
      end
      total++;
      if (bsy !== e.lat - skip) begin
         bad++;
         $display("FAIL %s busy cycles: got %0d want %0d", name, bsy, e.lat - skip);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy at done: got %b want 0", name, busy);
      end
      total++;
      if (result !== e.res) begin
         bad++;
         $display("FAIL %s result: got %h want %h", name, result, e.res);
      end
      total++;
      if (zero !== e.z) begin
         bad++;
         $display("FAIL %s zero: got %b want %b", name, zero, e.z);
      end
      total++;
      if (hi !== e.hi) begin
         bad++;
         $display("FAIL %s hi: got %h want %h", name, hi, e.hi);
      end
      total++;
      if (lo !== e.lo) begin
         bad++;
         $display("FAIL %s lo: got %h want %h", name, lo, e.lo);
      end
   endtask

   // Checks that every output reads zero.
   task automatic check_all_zero(input string name);
      total++;
      if ({busy, done, zero, result, hi, lo} !== {3'b000, 96'h0}) begin
         bad++;
         $display("FAIL %s: busy=%b done=%b zero=%b result=%h hi=%h lo=%h want all 0",
                  name, busy, done, zero, result, hi, lo);
      end
   endtask

   // Counts done pulses over a window with no request outstanding.
   task automatic check_quiet(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done !== 1'b0) seen++;
      end
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL %s: got %0d spurious done cycles want 0", name, seen);
      end
   endtask

   task automatic test_reset();
      start      = 1'b0;
      a          = 32'h0;
      b          = 32'h0;
      alucontrol = 3'b000;
      reset      = 1'b0;
      #1 reset   = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("after_reset_idle");
   endtask

   task automatic test_add_sub();
      drive_start(C_ADD, 32'd7, 32'd5);
      check_done("add_7_5", 0);
      drive_start(C_SUB, 32'd5, 32'd5);
      check_done("sub_5_5", 0);
      drive_start(C_ADD, 32'hFFFF_FFFF, 32'd1);
      check_done("add_wrap", 0);
   endtask

   task automatic test_slt_nor();
      drive_start(C_SLT, 32'hFFFF_FFFF, 32'd1);
      check_done("slt_neg_pos", 0);
      drive_start(C_SLT, 32'd1, 32'hFFFF_FFFF);
      check_done("slt_pos_neg", 0);
      drive_start(C_NOR, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
      check_done("nor_full", 0);
      drive_start(C_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
      check_done("and", 0);
      drive_start(C_OR, 32'h0000_1200, 32'h8000_0034);
      check_done("or", 0);
   endtask

   task automatic test_bne();
      drive_start(C_BNE, 32'd3, 32'd4);
      check_done("bne_diff", 0);
      drive_start(C_BNE, 32'd9, 32'd9);
      check_done("bne_equal", 0);
   endtask

   task automatic test_mult();
      drive_start(C_MULT, 32'hFFFF_FFFD, 32'd7);
      check_done("mult_m3_7", 0);
      @(negedge clk);
      total++;
      if (done !== 1'b0) begin
         bad++;
         $display("FAIL mult_done_pulse: got %b want 0", done);
      end
      drive_start(C_MULT, 32'h8000_0000, 32'h8000_0000);
      check_done("mult_min_min", 0);
      drive_start(C_ADD, 32'd1, 32'd2);
      check_done("add_keeps_hilo", 0);
      drive_start(C_MULT, 32'd0, 32'h1234_5678);
      check_done("mult_zero", 0);
   endtask

   task automatic test_back_to_back();
      drive_start(C_MULT, 32'd12345, 32'hFFFF_FD5A);
      repeat (4) @(negedge clk);
      // add request while busy: must not be accepted
      start      = 1'b1;
      alucontrol = C_ADD;
      a          = 32'd100;
      b          = 32'd200;
      @(negedge clk);
      start      = 1'b0;
      check_done("mult_with_ignored_start", 5);
      drive_start(C_ADD, 32'd40, 32'd2);
      check_done("add_in_done_cycle", 0);
      drive_start(C_SUB, 32'd10, 32'd3);
      check_done("sub_back_to_back", 0);
      check_quiet("no_extra_done", 5);
   endtask

   task automatic test_reset_mid_mult();
      start      = 1'b1;
      alucontrol = C_MULT;
      a          = 32'd1000;
      b          = 32'd3000;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_all_zero("reset_mid_mult");
      m_hi = 32'h0;
      m_lo = 32'h0;
      @(negedge clk);
      reset = 1'b0;
      check_quiet("no_done_after_abort", 40);
      drive_start(C_MULT, 32'd6, 32'd7);
      check_done("mult_6_7_after_reset", 0);
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_slt_nor();
      test_bne();
      test_mult();
      test_back_to_back();
      test_reset_mid_mult();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
